// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline with variable-latency loads: per-register
// pending scoreboard, ID stall, operand forwarding select and branch flush.
module hazard_scoreboard #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MAX_LD     = 4,
  parameter int unsigned FLUSH_W    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]             id_src_used,
  input  logic [REG_ADDR_W-1:0]          id_rd,
  input  logic                           id_is_load,
  input  logic [REG_ADDR_W-1:0]          exmem_rd,
  input  logic                           exmem_wr,
  input  logic [DATA_W-1:0]              exmem_data,
  input  logic [REG_ADDR_W-1:0]          memwb_rd,
  input  logic                           memwb_wr,
  input  logic [DATA_W-1:0]              memwb_data,
  input  logic                           ld_ret_valid,
  input  logic [REG_ADDR_W-1:0]          ld_ret_rd,
  input  logic [DATA_W-1:0]              ld_ret_data,
  input  logic                           branch_taken,
  output logic                           stall,
  output logic [FLUSH_W-1:0]             flush,
  output logic [2*NUM_SRC-1:0]           fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]      fwd_data,
  output logic                           ld_full
);

  localparam int unsigned NUM_REGS = 2**REG_ADDR_W;
  localparam int unsigned CNT_W    = $clog2(MAX_LD + 1);
  localparam int unsigned SUM_W    = CNT_W + 1;

  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_LDRET = 2'b11;

  logic [NUM_REGS-1:0]         r_pending;
  logic [CNT_W-1:0]            r_outstanding;
  logic                        r_ex_ld_vld;
  logic [REG_ADDR_W-1:0]       r_ex_ld_rd;

  logic [REG_ADDR_W-1:0]       w_src [NUM_SRC];
  logic [2*NUM_SRC-1:0]        w_fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   w_fwd_data;
  logic                        w_src_hazard;
  logic                        w_full;
  logic                        w_load_full;
  logic                        w_stall;
  logic                        w_issue_ld;
  logic                        w_squash;
  logic [NUM_REGS-1:0]         w_pending_nxt;
  logic [SUM_W-1:0]            w_out_sum;
  logic [SUM_W-1:0]            w_out_dec;
  logic [CNT_W-1:0]            w_out_nxt;

  // Per-source forwarding priority and unresolved-source detection
  always_comb begin
    w_fwd_sel    = '0;
    w_fwd_data   = '0;
    w_src_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src[i] = id_src[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_src_used[i] && (w_src[i] != '0)) begin
        if (exmem_wr && (exmem_rd == w_src[i])) begin
          w_fwd_sel[2*i +: 2]         = SEL_EXMEM;
          w_fwd_data[i*DATA_W +: DATA_W] = exmem_data;
        end else if (ld_ret_valid && (ld_ret_rd == w_src[i])) begin
          w_fwd_sel[2*i +: 2]         = SEL_LDRET;
          w_fwd_data[i*DATA_W +: DATA_W] = ld_ret_data;
        end else if (memwb_wr && (memwb_rd == w_src[i])) begin
          w_fwd_sel[2*i +: 2]         = SEL_MEMWB;
          w_fwd_data[i*DATA_W +: DATA_W] = memwb_data;
        end
        if (r_pending[w_src[i]] && !(ld_ret_valid && (ld_ret_rd == w_src[i])))
          w_src_hazard = 1'b1;
      end
    end
  end

  assign w_full      = (r_outstanding == CNT_W'(MAX_LD));
  assign w_load_full = id_is_load & w_full & ~ld_ret_valid;
  assign w_stall     = id_valid & ~branch_taken & (w_src_hazard | w_load_full);
  assign w_issue_ld  = id_valid & ~w_stall & ~branch_taken & id_is_load;
  assign w_squash    = branch_taken & r_ex_ld_vld;

  // Outputs forced quiet while reset is asserted
  assign stall    = rst & w_stall;
  assign flush    = rst ? {FLUSH_W{branch_taken}} : '0;
  assign fwd_sel  = rst ? w_fwd_sel : '0;
  assign fwd_data = rst ? w_fwd_data : '0;
  assign ld_full  = rst & w_full;

  // Set on load issue takes priority over clear by return or squash
  always_comb begin
    w_pending_nxt = r_pending;
    if (ld_ret_valid) w_pending_nxt[ld_ret_rd]  = 1'b0;
    if (w_squash)     w_pending_nxt[r_ex_ld_rd] = 1'b0;
    if (w_issue_ld)   w_pending_nxt[id_rd]      = 1'b1;
  end

  // Outstanding count saturates at zero so stray returns after reset are harmless
  always_comb begin
    w_out_sum = SUM_W'(r_outstanding) + SUM_W'(w_issue_ld);
    w_out_dec = SUM_W'(ld_ret_valid) + SUM_W'(w_squash);
    w_out_nxt = (w_out_dec > w_out_sum) ? '0 : CNT_W'(w_out_sum - w_out_dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_ex_ld_vld   <= 1'b0;
      r_ex_ld_rd    <= '0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_out_nxt;
      r_ex_ld_vld   <= w_issue_ld;
      r_ex_ld_rd    <= id_rd;
    end
  end

endmodule
